// File: rtl/filter_feeder.sv
// Weight-load and pixel-stream sequencer for the filter3x3 PE: writes nine
// weights, arms the filter with address 10, then streams ROWS*COLS pixels.
module filter_feeder #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned ROWS     = 480,
  parameter int unsigned COLS     = 640
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [9*BITWIDTH-1:0]   cfg_weight,
  input  logic                    pix_in_valid,
  input  logic [BITWIDTH-1:0]     pix_in,
  output logic                    pix_in_ready,
  input  logic                    filter_ready,
  output logic                    weight_in_valid,
  output logic [BITWIDTH-1:0]     weight,
  output logic [3:0]              weight_addr,
  output logic                    data_in_valid,
  output logic [BITWIDTH-1:0]     din,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned NPIX = ROWS * COLS;
  localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);
  localparam logic [3:0] ADDR_ARM  = 4'd10;
  localparam logic [3:0] ADDR_IDLE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BITWIDTH-1:0]   wcopy_q [9];
  logic [BITWIDTH-1:0]   wcopy_d [9];
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            idx_nxt;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wiv_q, wiv_d;
  logic [BITWIDTH-1:0]   weight_q, weight_d;
  logic [3:0]            addr_q, addr_d;
  logic                  dvalid_q, dvalid_d;
  logic [BITWIDTH-1:0]   din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;

  assign pix_in_ready = (state_q == S_STREAM) && filter_ready;
  assign accept       = pix_in_ready && pix_in_valid;
  assign idx_nxt      = idx_q + 4'd1;

  // Outputs are assigned in the branch of the state that precedes them, so
  // done appears the cycle after DONE and busy drops one cycle into IDLE.
  always_comb begin
    state_d  = state_q;
    wcopy_d  = wcopy_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wiv_d    = wiv_q;
    weight_d = weight_q;
    addr_d   = addr_q;
    dvalid_d = 1'b0;
    din_d    = din_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        addr_d = ADDR_IDLE;
        wiv_d  = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          for (int unsigned k = 0; k < 9; k++) begin
            wcopy_d[k] = cfg_weight[BITWIDTH*k +: BITWIDTH];
          end
          idx_d    = '0;
          cnt_d    = '0;
          addr_d   = 4'd0;
          wiv_d    = 1'b1;
          weight_d = cfg_weight[0 +: BITWIDTH];
          busy_d   = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (idx_q == 4'd8) begin
          wiv_d   = 1'b0;
          addr_d  = ADDR_ARM;
          state_d = S_ARM;
        end else begin
          idx_d    = idx_nxt;
          addr_d   = idx_nxt;
          weight_d = wcopy_q[idx_nxt];
          wiv_d    = 1'b1;
        end
      end
      S_ARM: begin
        wiv_d  = 1'b0;
        addr_d = ADDR_ARM;
        if (filter_ready) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        addr_d = ADDR_ARM;
        if (accept) begin
          din_d    = pix_in;
          dvalid_d = 1'b1;
          if (cnt_q == LAST_PIX) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        addr_d  = ADDR_ARM;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wcopy_q  <= '{default: '0};
      idx_q    <= '0;
      cnt_q    <= '0;
      wiv_q    <= 1'b0;
      weight_q <= '0;
      addr_q   <= ADDR_IDLE;
      dvalid_q <= 1'b0;
      din_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcopy_q  <= wcopy_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wiv_q    <= wiv_d;
      weight_q <= weight_d;
      addr_q   <= addr_d;
      dvalid_q <= dvalid_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign weight_in_valid = wiv_q;
  assign weight          = weight_q;
  assign weight_addr     = addr_q;
  assign data_in_valid   = dvalid_q;
  assign din             = din_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_filter_feeder.sv
// Randomized directed bench for filter_feeder (ROWS=3, COLS=4): per-cycle
// samples are logged and judged against frame-level expectations.
module tb_filter_feeder;

  localparam int BW = 8;
  localparam int NP = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [9*BW-1:0]   cfg_weight;
  logic              pix_in_valid;
  logic [BW-1:0]     pix_in;
  logic              pix_in_ready;
  logic              filter_ready;
  logic              weight_in_valid;
  logic [BW-1:0]     weight;
  logic [3:0]        weight_addr;
  logic              data_in_valid;
  logic [BW-1:0]     din;
  logic              busy;
  logic              done;

  filter_feeder #(.BITWIDTH(BW), .ROWS(3), .COLS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_weight(cfg_weight),
    .pix_in_valid(pix_in_valid), .pix_in(pix_in), .pix_in_ready(pix_in_ready),
    .filter_ready(filter_ready), .weight_in_valid(weight_in_valid),
    .weight(weight), .weight_addr(weight_addr), .data_in_valid(data_in_valid),
    .din(din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pr;
    logic       wiv;
    logic [3:0] a;
    logic [7:0] w;
    logic       dv;
    logic [7:0] d;
    logic       busy;
    logic       done;
  } samp_t;

  samp_t      lg[$];
  logic [7:0] src[$];
  int         hs;
  int         n_assert = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the combinational ready and handshake before the edge,
  // registered outputs 1 time unit after it.
  task automatic tick();
    samp_t s;
    #1;
    s.pr = pix_in_ready;
    chk("ready_implies_filter_ready", {31'd0, pix_in_ready & ~filter_ready}, 0);
    if (pix_in_valid && pix_in_ready && src.size() > 0) begin
      void'(src.pop_front());
      hs++;
    end
    @(posedge clk);
    #1;
    s.wiv = weight_in_valid; s.a = weight_addr; s.w = weight;
    s.dv = data_in_valid; s.d = din; s.busy = busy; s.done = done;
    lg.push_back(s);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_pix_in_ready"}, pix_in_ready, 0);
    chk({nm, "_weight_in_valid"}, weight_in_valid, 0);
    chk({nm, "_weight"}, weight, 0);
    chk({nm, "_weight_addr"}, weight_addr, 4'hF);
    chk({nm, "_data_in_valid"}, data_in_valid, 0);
    chk({nm, "_din"}, din, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  task automatic run_frame(input string nm, input int arm_wait, input bit stall,
                           input bit busy_start, input bit seq);
    logic [7:0] wts[9];
    logic [7:0] exp_pix[$];
    logic [7:0] got[$];
    int r, last, first, nd, nw, bad, drop_left;
    bit dropped;
    r = 10 + arm_wait;
    for (int k = 0; k < 9; k++) begin
      wts[k] = seq ? 8'(k + 1) : 8'($urandom);
      cfg_weight[k*BW +: BW] = wts[k];
    end
    exp_pix.delete();
    for (int i = 0; i < NP; i++) exp_pix.push_back(seq ? 8'(8'h10 + i) : 8'($urandom));
    src = exp_pix;
    lg.delete();
    hs = 0; dropped = 0; drop_left = 0;
    start = 1; filter_ready = 0; pix_in_valid = 0; pix_in = '0;
    tick();
    start = 0;
    for (int k = 0; k < 9; k++) cfg_weight[k*BW +: BW] = 8'($urandom);
    for (int i = 1; i < 400 && lg[lg.size()-1].busy !== 1'b0; i++) begin
      start = busy_start && (i == 3 || i == r + 4);
      if (stall && hs == 6 && !dropped) begin
        dropped = 1; drop_left = 3;
      end
      if (drop_left > 0) begin
        filter_ready = 0; drop_left--;
      end else begin
        filter_ready = (i >= r);
      end
      pix_in_valid = (src.size() > 0) && (!stall || $urandom_range(0, 1) == 1);
      pix_in = (src.size() > 0) ? src[0] : 8'($urandom);
      tick();
    end
    start = 0; pix_in_valid = 0; filter_ready = 0;
    chk({nm, "_frame_ends"}, lg[lg.size()-1].busy, 0);

    for (int k = 0; k < 9 && k < lg.size(); k++) begin
      chk($sformatf("%s_wiv_%0d", nm, k), lg[k].wiv, 1);
      chk($sformatf("%s_waddr_%0d", nm, k), lg[k].a, k);
      chk($sformatf("%s_wdata_%0d", nm, k), lg[k].w, wts[k]);
      chk($sformatf("%s_busy_load_%0d", nm, k), lg[k].busy, 1);
    end
    if (lg.size() > 9) begin
      chk({nm, "_arm_addr"}, lg[9].a, 10);
      chk({nm, "_arm_wiv"}, lg[9].wiv, 0);
    end
    nw = 0; nd = 0; last = -1; first = -1; bad = 0;
    got.delete();
    foreach (lg[i]) begin
      if (lg[i].wiv === 1'b1) nw++;
      if (lg[i].done === 1'b1) nd++;
      if (lg[i].dv === 1'b1) begin
        got.push_back(lg[i].d);
        if (first < 0) first = i;
        last = i;
      end
      if (i <= r && (lg[i].pr === 1'b1 || lg[i].dv === 1'b1)) bad++;
    end
    chk({nm, "_weight_writes"}, nw, 9);
    chk({nm, "_handshakes"}, hs, NP);
    chk({nm, "_pixels_out"}, got.size(), NP);
    for (int i = 0; i < NP && i < got.size(); i++)
      chk($sformatf("%s_pix_%0d", nm, i), got[i], exp_pix[i]);
    chk({nm, "_no_stream_before_ready"}, bad, 0);
    if (!stall) chk({nm, "_first_pixel_cycle"}, first, r + 1);
    chk({nm, "_done_pulses"}, nd, 1);
    if (last >= 0 && last + 2 < lg.size()) begin
      chk({nm, "_done_after_last"}, lg[last+1].done, 1);
      chk({nm, "_busy_with_done"}, lg[last+1].busy, 1);
      chk({nm, "_addr_with_done"}, lg[last+1].a, 10);
      chk({nm, "_busy_falls"}, lg[last+2].busy, 0);
      chk({nm, "_addr_idle"}, lg[last+2].a, 4'hF);
      bad = 0;
      for (int i = 9; i <= last + 1; i++) if (lg[i].a !== 4'd10) bad++;
      for (int i = last + 1; i < lg.size(); i++) if (lg[i].pr === 1'b1) bad++;
      chk({nm, "_addr10_and_ready_window"}, bad, 0);
    end else begin
      chk({nm, "_tail_present"}, last, -2);
    end
  endtask

  initial begin
    rst = 1; start = 0; cfg_weight = '0; pix_in_valid = 0; pix_in = '0; filter_ready = 0;
    #1 rst = 0;
    #1 check_reset_outputs("por");
    #20 rst = 1;
    tick(); tick();

    run_frame("wload_armwait", 20, 1'b0, 1'b0, 1'b1);
    tick();
    run_frame("stall", 0, 1'b1, 1'b0, 1'b0);
    tick();
    run_frame("busy_start", 3, 1'b0, 1'b1, 1'b0);
    tick();

    // Abandon a frame five pixels into the stream
    for (int k = 0; k < 9; k++) cfg_weight[k*BW +: BW] = 8'($urandom);
    src.delete();
    for (int i = 0; i < NP; i++) src.push_back(8'($urandom));
    lg.delete(); hs = 0;
    start = 1; tick(); start = 0;
    for (int i = 1; i < 60 && hs < 5; i++) begin
      filter_ready = (i >= 10);
      pix_in_valid = 1;
      pix_in = src[0];
      tick();
    end
    chk("midframe_pixels_before_reset", hs, 5);
    pix_in_valid = 1; filter_ready = 1;
    #2 rst = 0;
    #1 check_reset_outputs("midframe_rst");
    #10 rst = 1;
    pix_in_valid = 0; filter_ready = 0;
    tick(); tick();
    run_frame("after_rst", 1, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
